// File: rtl/song_sequencer.sv
// Auto-play note sequencer: walks a song ROM entry by entry, sounding each entry
// for a programmed number of beats followed by a fixed silent gap.
module song_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000,
    parameter int unsigned SONG_LEN    = 32,
    parameter int unsigned ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    output logic [3:0]        note,
    output logic [1:0]        octave_auto,
    output logic              playing,
    output logic              done
);

    localparam int unsigned MAXC = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0]     BEAT_LAST = CW'(BEAT_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TONE,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [CW-1:0]     cyc_cnt, cyc_d;
    logic [3:0]        beat_cnt, beat_d;
    logic [3:0]        note_lat, note_lat_d;
    logic [1:0]        oct_lat, oct_lat_d;
    logic [3:0]        beats_lat, beats_lat_d;
    logic [3:0]        note_d;
    logic [1:0]        oct_d;
    logic              playing_d, done_d;
    logic              hold, advance;

    logic [3:0] rom_note;
    logic [1:0] rom_oct;
    logic [3:0] rom_beats;

    assign rom_note  = rom_data[9:6];
    assign rom_oct   = rom_data[5:4];
    assign rom_beats = rom_data[3:0];

    always_comb begin
        state_d     = state;
        addr_d      = rom_addr;
        cyc_d       = cyc_cnt;
        beat_d      = beat_cnt;
        note_lat_d  = note_lat;
        oct_lat_d   = oct_lat;
        beats_lat_d = beats_lat;
        hold        = 1'b0;
        advance     = 1'b0;

        if (stop && state != S_IDLE) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end else if (pause && (state == S_LOAD || state == S_TONE || state == S_GAP)) begin
            hold = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    addr_d = '0;
                    if (start && !stop) state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (rom_beats == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        note_lat_d  = (rom_note > 4'd7) ? 4'd0 : rom_note;
                        oct_lat_d   = rom_oct;
                        beats_lat_d = rom_beats;
                        cyc_d       = '0;
                        beat_d      = '0;
                        state_d     = S_TONE;
                    end
                end
                S_TONE: begin
                    if (cyc_cnt == BEAT_LAST) begin
                        cyc_d = '0;
                        if (beat_cnt == beats_lat - 4'd1) begin
                            if (GAP_CYCLES > 0) state_d = S_GAP;
                            else                advance = 1'b1;
                        end else begin
                            beat_d = beat_cnt + 4'd1;
                        end
                    end else begin
                        cyc_d = cyc_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cyc_cnt == GAP_LAST) begin
                        cyc_d   = '0;
                        advance = 1'b1;
                    end else begin
                        cyc_d = cyc_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (advance) begin
            if (rom_addr == ADDR_LAST) begin
                state_d = S_DONE;
            end else begin
                addr_d  = rom_addr + ADDR_W'(1);
                state_d = S_LOAD;
            end
        end

        // Outputs are derived from the next state so they register in step with it.
        note_d    = (state_d == S_TONE && !hold) ? note_lat_d : 4'd0;
        oct_d     = (state_d == S_IDLE) ? 2'b00 :
                    (state_d == S_TONE) ? oct_lat_d : octave_auto;
        playing_d = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rom_addr    <= '0;
            cyc_cnt     <= '0;
            beat_cnt    <= '0;
            note_lat    <= '0;
            oct_lat     <= '0;
            beats_lat   <= '0;
            note        <= '0;
            octave_auto <= '0;
            playing     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            rom_addr    <= addr_d;
            cyc_cnt     <= cyc_d;
            beat_cnt    <= beat_d;
            note_lat    <= note_lat_d;
            oct_lat     <= oct_lat_d;
            beats_lat   <= beats_lat_d;
            note        <= note_d;
            octave_auto <= oct_d;
            playing     <= playing_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios plus random control traffic, all
// checked every cycle against a per-song timeline model built from the ROM contents.
module tb_song_sequencer;

    localparam int BEAT = 4;
    localparam int GAP  = 2;
    localparam int LEN  = 4;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [9:0]    rom_data;
    logic [3:0]    note;
    logic [1:0]    octave_auto;
    logic          playing;
    logic          done;

    logic [9:0] rom_mem [LEN];
    assign rom_data = rom_mem[rom_addr];

    song_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .SONG_LEN   (LEN),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note       (note),
        .octave_auto(octave_auto),
        .playing    (playing),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One timeline position per output cycle of an unpaused song.
    typedef struct {
        int addr;
        int nt;
        int oct;
        bit is_done;
        bit pausable;
    } pos_t;

    pos_t trace[$];
    int   p = -1;
    bit   masked = 1'b0;

    function automatic void push(int a, int n, int o, bit d, bit pz);
        pos_t e;
        e.addr = a; e.nt = n; e.oct = o; e.is_done = d; e.pausable = pz;
        trace.push_back(e);
    endfunction

    function automatic void build_trace();
        int prev_oct = 0;
        trace.delete();
        for (int i = 0; i < LEN; i++) begin
            int nt, oc, bt;
            logic [9:0] w;
            w  = rom_mem[i];
            nt = int'(w[9:6]);
            oc = int'(w[5:4]);
            bt = int'(w[3:0]);
            push(i, 0, prev_oct, 1'b0, 1'b1);
            if (bt == 0) begin
                push(i, 0, prev_oct, 1'b1, 1'b0);
                return;
            end
            if (nt > 7) nt = 0;
            for (int k = 0; k < bt * BEAT; k++) push(i, nt, oc, 1'b0, 1'b1);
            for (int k = 0; k < GAP; k++) push(i, 0, oc, 1'b0, 1'b1);
            prev_oct = oc;
            if (i == LEN - 1) push(i, 0, oc, 1'b1, 1'b0);
        end
    endfunction

    task automatic tick();
        int ea, en, eo, ep, ed;
        @(posedge clk);
        if (rst) begin
            p = -1; masked = 1'b0;
        end else if (p < 0) begin
            masked = 1'b0;
            if (start && !stop) begin
                build_trace();
                p = 0;
            end
        end else if (stop) begin
            p = -1; masked = 1'b0;
        end else if (pause && trace[p].pausable) begin
            masked = 1'b1;
        end else begin
            masked = 1'b0;
            p++;
            if (p >= trace.size()) p = -1;
        end
        #1;
        if (p < 0) begin
            ea = 0; en = 0; eo = 0; ep = 0; ed = 0;
        end else begin
            ea = trace[p].addr;
            en = masked ? 0 : trace[p].nt;
            eo = trace[p].oct;
            ep = 1;
            ed = int'(trace[p].is_done);
        end
        chk("rom_addr", int'(rom_addr), ea);
        chk("note", int'(note), en);
        chk("octave_auto", int'(octave_auto), eo);
        chk("playing", int'(playing), ep);
        chk("done", int'(done), ed);
    endtask

    function automatic void set_rom(logic [9:0] a, logic [9:0] b, logic [9:0] c, logic [9:0] d);
        rom_mem[0] = a; rom_mem[1] = b; rom_mem[2] = c; rom_mem[3] = d;
    endfunction

    // Plays one song from a start pulse; n counts the cycle shown after each edge (LOAD of entry 0 is 1).
    task automatic play(input int pause_at, input int pause_len, input int stop_at, input int start_at,
                        output int n_done, output int audible0, output int max_addr);
        int n;
        n_done = -1; audible0 = 0; max_addr = 0;
        start = 1'b1;
        tick();
        n = 1;
        start = 1'b0;
        while (n < 300) begin
            pause = (n >= pause_at && n < pause_at + pause_len);
            stop  = (n == stop_at);
            start = (n == start_at);
            tick();
            n++;
            if (note != 4'd0 && rom_addr == '0) audible0++;
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            if (done) begin
                n_done = n;
                break;
            end
            if (!playing) break;
        end
        pause = 1'b0; stop = 1'b0; start = 1'b0;
        if (n >= 300) chk("song_timeout", n, 0);
        tick();
    endtask

    logic [9:0] basic [4];
    int nd, aud, mx;

    initial begin
        basic[0] = {4'd1, 2'b00, 4'd2};
        basic[1] = {4'd5, 2'b10, 4'd1};
        basic[2] = {4'd0, 2'b00, 4'd1};
        basic[3] = {4'd7, 2'b01, 4'd3};
        set_rom(basic[0], basic[1], basic[2], basic[3]);

        rst = 1'b1; start = 1'b1;
        tick(); tick();
        rst = 1'b0; start = 1'b0;
        tick(); tick();

        play(-1, 0, -1, -1, nd, aud, mx);
        chk("basic_done_cycle", nd, 41);
        chk("basic_entry0_audible", aud, 8);

        set_rom(basic[0], {4'd5, 2'b10, 4'd0}, basic[2], basic[3]);
        play(-1, 0, -1, -1, nd, aud, mx);
        chk("endmark_done_cycle", nd, 13);
        chk("endmark_max_addr", mx, 1);
        set_rom(basic[0], basic[1], basic[2], basic[3]);

        play(4, 5, -1, -1, nd, aud, mx);
        chk("pause_done_cycle", nd, 46);
        chk("pause_entry0_audible", aud, 8);

        play(-1, 0, 17, -1, nd, aud, mx);
        chk("stop_no_done", nd, -1);
        chk("stop_addr", int'(rom_addr), 0);
        play(-1, 0, -1, -1, nd, aud, mx);
        chk("replay_done_cycle", nd, 41);

        play(-1, 0, -1, 5, nd, aud, mx);
        chk("start_in_tone_done_cycle", nd, 41);

        play(6, 3, 6, -1, nd, aud, mx);
        chk("stop_pause_no_done", nd, -1);

        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_tone_note", int'(note), 0);
        tick();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (p < 0 && $urandom_range(0, 7) == 0) begin
                for (int i = 0; i < LEN; i++) begin
                    logic [3:0] bt;
                    logic [3:0] nt;
                    logic [1:0] oc;
                    bt = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
                    nt = 4'($urandom_range(0, 15));
                    oc = 2'($urandom_range(0, 3));
                    rom_mem[i] = {nt, oc, bt};
                end
            end
            start = ($urandom_range(0, 5) == 0);
            pause = ($urandom_range(0, 4) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
